// File: rtl/threshold_monitor_pkg.sv
// ============================================================================
// threshold_monitor_pkg
// Shared FSM state encoding and default parameter values for threshold_monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package threshold_monitor_pkg;

    localparam int c_default_n_trig = 3;
    localparam int c_default_n_clr  = 2;
    localparam int c_default_cnt_w  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MONITOR  = 3'd1,
        ST_PENDING  = 3'd2,
        ST_ALARM    = 3'd3,
        ST_CLEARING = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/threshold_monitor_if.sv
// ============================================================================
// threshold_monitor_if
// Threshold write, sample handshake and result/alarm bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface threshold_monitor_if
    import threshold_monitor_pkg::*;
#(
    parameter int CNT_W = c_default_cnt_w
);
    logic             thr_we;
    logic [3:0]       thr_d;
    logic             s_valid;
    logic [3:0]       s_data;
    logic             s_ready;
    logic             cmp_valid;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             alarm;
    logic [CNT_W-1:0] alarm_cnt;

    modport master (
        output thr_we, thr_d, s_valid, s_data,
        input  s_ready, cmp_valid, cmp_gt, cmp_lt, cmp_eq, alarm, alarm_cnt
    );

    modport slave (
        input  thr_we, thr_d, s_valid, s_data,
        output s_ready, cmp_valid, cmp_gt, cmp_lt, cmp_eq, alarm, alarm_cnt
    );

endinterface

`default_nettype wire

// File: rtl/threshold_monitor_mag_cmp4.sv
// ============================================================================
// mag_cmp4
// Combinational unsigned 4-bit magnitude comparator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mag_cmp4 (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    output logic            gt,
    output logic            lt,
    output logic            eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

`default_nettype wire

// File: rtl/threshold_monitor.sv
// ============================================================================
// threshold_monitor
// Debounced over-threshold alarm on a 4-bit sample stream with alarm counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module threshold_monitor
    import threshold_monitor_pkg::*;
#(
    parameter int N_TRIG = c_default_n_trig,
    parameter int N_CLR  = c_default_n_clr,
    parameter int CNT_W  = c_default_cnt_w
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    threshold_monitor_if.slave    bus
);

    localparam logic [3:0] c_trig = 4'(N_TRIG);
    localparam logic [3:0] c_clr  = 4'(N_CLR);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_thr;
    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [3:0]       r_clr;
    logic [3:0]       w_clr_nxt;
    logic             r_cmp_valid;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic             r_alarm;
    logic [CNT_W-1:0] r_alarm_cnt;
    logic             w_cnt_inc;
    logic             w_s_ready;
    logic             w_accept;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;

    assign w_s_ready = (r_state != ST_IDLE) && !bus.thr_we;
    assign w_accept  = bus.s_valid && w_s_ready;

    mag_cmp4 u_mag_cmp4 (
        .a  (bus.s_data),
        .b  (r_thr),
        .gt (w_gt),
        .lt (w_lt),
        .eq (w_eq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_thr       <= 4'd0;
            r_run       <= 4'd0;
            r_clr       <= 4'd0;
            r_cmp_valid <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_clr       <= w_clr_nxt;
            r_cmp_valid <= w_accept;
            r_alarm     <= (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_CLEARING);
            if (bus.thr_we) begin
                r_thr <= bus.thr_d;
            end
            if (w_accept) begin
                r_gt <= w_gt;
                r_lt <= w_lt;
                r_eq <= w_eq;
            end
            if (w_cnt_inc && (r_alarm_cnt != '1)) begin
                r_alarm_cnt <= r_alarm_cnt + CNT_W'(1);
            end
        end
    end

    // A threshold write re-arms the monitor and discards any run or clear progress.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_clr_nxt   = r_clr;
        w_cnt_inc   = 1'b0;
        if (bus.thr_we) begin
            w_state_nxt = ST_MONITOR;
            w_run_nxt   = 4'd0;
            w_clr_nxt   = 4'd0;
        end else if (w_accept) begin
            case (r_state)
                ST_MONITOR: begin
                    if (w_gt) begin
                        if (c_trig == 4'd1) begin
                            w_state_nxt = ST_ALARM;
                            w_run_nxt   = 4'd0;
                            w_cnt_inc   = 1'b1;
                        end else begin
                            w_state_nxt = ST_PENDING;
                            w_run_nxt   = 4'd1;
                        end
                    end
                end
                ST_PENDING: begin
                    if (w_gt) begin
                        if ((r_run + 4'd1) == c_trig) begin
                            w_state_nxt = ST_ALARM;
                            w_run_nxt   = 4'd0;
                            w_cnt_inc   = 1'b1;
                        end else begin
                            w_run_nxt = r_run + 4'd1;
                        end
                    end else begin
                        w_state_nxt = ST_MONITOR;
                        w_run_nxt   = 4'd0;
                    end
                end
                ST_ALARM: begin
                    if (!w_gt) begin
                        if (c_clr == 4'd1) begin
                            w_state_nxt = ST_MONITOR;
                            w_clr_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_CLEARING;
                            w_clr_nxt   = 4'd1;
                        end
                    end
                end
                ST_CLEARING: begin
                    if (!w_gt) begin
                        if ((r_clr + 4'd1) == c_clr) begin
                            w_state_nxt = ST_MONITOR;
                            w_clr_nxt   = 4'd0;
                        end else begin
                            w_clr_nxt = r_clr + 4'd1;
                        end
                    end else begin
                        // Re-entering ALARM from here is not a new assertion.
                        w_state_nxt = ST_ALARM;
                        w_clr_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.cmp_valid = r_cmp_valid;
    assign bus.cmp_gt    = r_gt;
    assign bus.cmp_lt    = r_lt;
    assign bus.cmp_eq    = r_eq;
    assign bus.alarm     = r_alarm;
    assign bus.alarm_cnt = r_alarm_cnt;

endmodule

`default_nettype wire

// File: tb/tb_threshold_monitor.sv
// ============================================================================
// tb_threshold_monitor
// Directed and random stimulus checked against a streak-based alarm model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_threshold_monitor;

    localparam int c_n_trig = 3;
    localparam int c_n_clr  = 2;
    localparam int c_cnt_w  = 8;
    localparam int c_cnt_max = (1 << c_cnt_w) - 1;

    logic clk;
    logic rst_n;

    threshold_monitor_if #(.CNT_W(c_cnt_w)) bus ();

    threshold_monitor #(
        .N_TRIG (c_n_trig),
        .N_CLR  (c_n_clr),
        .CNT_W  (c_cnt_w)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: armed flag, alarm flag and length of the current streak
    bit m_armed;
    bit m_alarm;
    int m_thr;
    int m_streak;
    int m_cnt;
    bit m_cmp_valid;
    bit m_gt, m_lt, m_eq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rstn, input bit we, input int d, input bit v, input int sd);
        bit acc;
        acc = v && m_armed && !we;
        if (!rstn) begin
            m_armed = 0; m_alarm = 0; m_thr = 0; m_streak = 0; m_cnt = 0;
            m_cmp_valid = 0; m_gt = 0; m_lt = 0; m_eq = 0;
        end else begin
            m_cmp_valid = acc;
            if (we) begin
                m_thr = d; m_armed = 1; m_alarm = 0; m_streak = 0;
            end else if (acc) begin
                m_gt = sd > m_thr;
                m_lt = sd < m_thr;
                m_eq = sd == m_thr;
                if (!m_alarm) begin
                    if (m_gt) begin
                        m_streak++;
                        if (m_streak >= c_n_trig) begin
                            m_alarm = 1; m_streak = 0;
                            if (m_cnt < c_cnt_max) m_cnt++;
                        end
                    end else m_streak = 0;
                end else begin
                    if (!m_gt) begin
                        m_streak++;
                        if (m_streak >= c_n_clr) begin
                            m_alarm = 0; m_streak = 0;
                        end
                    end else m_streak = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit rstn, input bit we, input int d, input bit v, input int sd);
        @(negedge clk);
        rst_n       = rstn;
        bus.thr_we  = we;
        bus.thr_d   = 4'(d);
        bus.s_valid = v;
        bus.s_data  = 4'(sd);
        #1;
        check("s_ready", 32'(bus.s_ready), 32'(m_armed && !we));
        model_edge(rstn, we, d, v, sd);
        @(posedge clk);
        #1;
        check("cmp_valid", 32'(bus.cmp_valid), 32'(m_cmp_valid));
        check("cmp_gt",    32'(bus.cmp_gt),    32'(m_gt));
        check("cmp_lt",    32'(bus.cmp_lt),    32'(m_lt));
        check("cmp_eq",    32'(bus.cmp_eq),    32'(m_eq));
        check("alarm",     32'(bus.alarm),     32'(m_alarm));
        check("alarm_cnt", 32'(bus.alarm_cnt), 32'(m_cnt));
    endtask

    task automatic sample(input int sd);
        cycle(1, 0, 0, 1, sd);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.thr_we = 1'b0; bus.thr_d = 4'd0; bus.s_valid = 1'b0; bus.s_data = 4'd0;
        model_edge(0, 0, 0, 0, 0);

        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3);
        check("reset_alarm_cnt", 32'(bus.alarm_cnt), 32'd0);

        // No threshold written: block stays idle
        for (int i = 0; i < 4; i++) sample(i + 7);
        check("idle_no_cmp", 32'(bus.cmp_valid), 32'd0);

        cycle(1, 1, 5, 0, 0);
        sample(5);
        check("eq_pulse", 32'({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq}), 32'b001);
        sample(4);
        check("lt_pulse", 32'({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq}), 32'b010);
        sample(6);
        check("gt_pulse", 32'({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq}), 32'b100);
        cycle(1, 0, 0, 0, 0);
        check("cmp_hold_gt", 32'(bus.cmp_gt), 32'd1);

        cycle(1, 1, 5, 0, 0);
        sample(6); sample(7);
        check("no_alarm_yet", 32'(bus.alarm), 32'd0);
        sample(8);
        check("alarm_rise", 32'({bus.cmp_valid, bus.alarm}), 32'b11);
        check("alarm_cnt_1", 32'(bus.alarm_cnt), 32'd1);

        sample(3); sample(9); sample(3);
        check("alarm_held", 32'(bus.alarm), 32'd1);
        sample(3);
        check("alarm_clear", 32'(bus.alarm), 32'd0);
        check("alarm_cnt_still_1", 32'(bus.alarm_cnt), 32'd1);

        cycle(1, 1, 5, 0, 0);
        sample(6); sample(6);
        cycle(1, 1, 9, 1, 10);
        check("we_blocks_accept", 32'(bus.cmp_valid), 32'd0);
        sample(10); sample(10);
        check("run_restarted", 32'(bus.alarm), 32'd0);
        sample(10);
        check("alarm_after_rewrite", 32'(bus.alarm), 32'd1);
        check("alarm_cnt_2", 32'(bus.alarm_cnt), 32'd2);

        cycle(0, 0, 0, 1, 12);
        check("rst_outputs", 32'({bus.cmp_valid, bus.cmp_gt, bus.cmp_lt, bus.cmp_eq, bus.alarm}), 32'd0);
        check("rst_cnt", 32'(bus.alarm_cnt), 32'd0);
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);

        // Drive the alarm counter past its saturation point
        cycle(1, 1, 2, 0, 0);
        for (int i = 0; i < c_cnt_max + 5; i++) begin
            sample(15); sample(15); sample(15);
            sample(0);  sample(1);
        end
        check("cnt_saturated", 32'(bus.alarm_cnt), 32'(c_cnt_max));

        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit rb, wb, vb;
            int dd, sd;
            rb = ($urandom_range(0, 299) != 0);
            wb = ($urandom_range(0, 24) == 0);
            vb = ($urandom_range(0, 3) != 0);
            dd = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1)
                sd = m_thr + $urandom_range(0, 4) - 2;
            else
                sd = $urandom_range(0, 15);
            if (sd < 0) sd = 0;
            if (sd > 15) sd = 15;
            cycle(rb, wb, dd, vb, sd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
